bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Programmable multi-digit BCD down counter. It is the count-down counterpart of the team's 0–9 decade up counter and serves as the timeout/interval generator next to it.
- Loads a BCD preset and decrements once per `enable` tick while running.
- Raises a one-cycle terminal-count strobe on reaching zero.
- Optionally auto-reloads the preset for periodic operation.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits; counter width is 4*DIGITS bits, digit 0 in bits [3:0]

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  capture `load_value` as count and preset
- load_value  in  4*DIGITS  BCD preset, each digit 0–9
- start  in  1  begin counting from current `q`
- stop  in  1  pause; `q` held
- enable  in  1  count tick (clock enable), one decrement per cycle high
- auto_reload  in  1  1 = periodic mode, 0 = one-shot
- q  out  4*DIGITS  current BCD count
- running  out  1  1 while in RUN state
- tc  out  1  one-cycle pulse in the cycle `q` first reads zero
- load_err  out  1  one-cycle pulse when a `load` was rejected

## Operation
- States:
  - IDLE: count frozen.
  - RUN: counting.
  - RELOAD: RUN sub-case in which `q`==0 and auto_reload is pending. Encoded as RUN with `q`==0.
- Reset (reset=0, asynchronous):
  - `q`=0, preset=0, state IDLE.
  - running=0, tc=0, load_err=0.
- Per-edge priority: load > stop > start > enable.
- load:
  - All digits valid: `q` and preset take `load_value`; state forced to IDLE.
  - Any digit >9: nothing changes (state unchanged); load_err=1 for one cycle.
- stop: state → IDLE, `q` unchanged. No effect in IDLE.
- start:
  - IDLE and `q`≠0: state → RUN.
  - `q`==0: ignored, stays IDLE.
  - Already in RUN: ignored.
- enable in RUN, `q`≠0: BCD decrement.
  - Digit 0 decrements.
  - Any digit at 0 wraps to 9 and borrows from the next digit; the borrow ripples through all digits in the same cycle.
  - Example: 1000 → 0999.
- Decrement result is zero:
  - tc=1 for exactly that cycle.
  - auto_reload=0 (sampled on that edge): state → IDLE.
  - auto_reload=1: stays RUN.
- enable in RUN with `q`==0 (auto_reload case): `q` ← preset, no tc. One period is therefore preset+1 ticks.
- enable in IDLE: no effect.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- load at edge k: `q`=load_value after edge k, running=0 after edge k.
- start at edge k: running=1 after edge k. An enable sampled at the same edge k does not decrement.
- Decrement latency: `q` updates on the same edge that samples enable=1.
- One-shot from preset N (≠0), started before the first tick: tc appears after the N-th tick edge with `q`=0, and running=0 from that same edge.
- Periodic: tc asserted every preset+1 ticks; the reload happens on the tick following tc.
- stop, or load, coincident with the final tick: stop/load wins; no decrement, no tc.
- load_err and tc never assert for more than one consecutive cycle per event.
- Reset asserted mid-count: all outputs clear immediately (asynchronous).
- Reset release: first functional edge is the first clk rising edge after reset returns high.

## Test plan
- Reset: hold reset=0 with random inputs.
  - Expect `q`=0000, running=0, tc=0, load_err=0.
  - Expect start with `q`=0 to keep running=0.
- One-shot: load 0025, start, 25 enable pulses.
  - Expect `q`: 0024…0001, 0000.
  - Expect tc high exactly in the cycle after the 25th tick edge.
  - Expect running=0 afterwards; further ticks leave `q`=0000.
- Borrow chain: load 1000, start, 1 tick → `q`=0999. Load 0100, start, 1 tick → `q`=0099.
- Auto-reload: load 0003, auto_reload=1, start, continuous enable.
  - Expect `q` sequence 2,1,0,3,2,1,0,3.
  - Expect tc every 4 cycles; running stays 1.
- Invalid load: running at `q`=0042, load 00A5.
  - Expect load_err pulse, `q` still 0042, still running.
  - Then load 0007: expect `q`=0007, running=0.
- Priority and reset: at `q`=0001 assert stop and enable together.
  - Expect `q`=0001, no tc, running=0.
  - Restart; assert reset=0 mid-cycle before the next tick edge: expect `q`=0000 asynchronously and no tc.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Programmable multi-digit BCD down counter used as a timeout / interval
//   generator. A validated BCD preset is loaded into the count, counting runs
//   between start and stop, and one BCD decrement happens per enable tick.
//   Reaching zero raises a one-cycle terminal-count strobe. In periodic mode
//   the count is reloaded from the preset on the tick after zero.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   load         capture load_value as count and preset (rejected if not BCD)
//   load_value   BCD preset, digit 0 in bits [3:0]
//   start        begin counting from the current q (ignored when q is zero)
//   stop         pause counting, q held
//   enable       count tick, one decrement per cycle high while running
//   auto_reload  1 = periodic, 0 = one-shot
//   q            current BCD count
//   running      high while counting
//   tc           one-cycle pulse in the cycle q first reads zero
//   load_err     one-cycle pulse after a rejected load
module bcd_countdown_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  enable,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  tc,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    // RUN with q == 0 is the pending-reload case of periodic mode, so it
    // needs no state of its own.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   preset;
    logic [W-1:0]   preset_next;
    logic [W-1:0]   q_next;
    logic           tc_next;
    logic           load_err_next;

    // True when every nibble is a legal BCD digit.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // BCD decrement with the borrow rippling through all digits in one cycle.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            q        <= '0;
            preset   <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            q        <= q_next;
            preset   <= preset_next;
            tc       <= tc_next;
            load_err <= load_err_next;
        end
    end

    // Command priority: load > stop > start > enable.
    always_comb begin
        state_next    = state;
        q_next        = q;
        preset_next   = preset;
        tc_next       = 1'b0;
        load_err_next = 1'b0;

        if (load) begin
            if (bcd_valid(load_value)) begin
                q_next      = load_value;
                preset_next = load_value;
                state_next  = IDLE;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            if (state == IDLE && q != '0) begin
                state_next = RUN;
            end
        end else if (enable && state == RUN) begin
            if (q == '0) begin
                // Periodic reload: the zero count itself costs one tick.
                q_next = preset;
            end else begin
                q_next = bcd_dec(q);
                if (q_next == '0) begin
                    tc_next = 1'b1;
                    if (!auto_reload) begin
                        state_next = IDLE;
                    end
                end
            end
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        stop;
    logic        enable;
    logic        auto_reload;
    logic [15:0] q;
    logic        running;
    logic        tc;
    logic        load_err;

    int n_vec;
    int n_err;

    typedef struct {
        logic [15:0] q;
        logic        run;
        logic        tc;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];

    bcd_countdown_timer #(.DIGITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .running     (running),
        .tc          (tc),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".q"},        {16'd0, q},         {16'd0, e.q});
            check({e.tag, ".running"},  {31'd0, running},   {31'd0, e.run});
            check({e.tag, ".tc"},       {31'd0, tc},        {31'd0, e.tc});
            check({e.tag, ".load_err"}, {31'd0, load_err},  {31'd0, e.err});
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), record the
    // expected outputs after the next rising edge, then sample #1 later.
    task automatic step(input logic ld, input logic [15:0] lv, input logic st,
                        input logic sp, input logic en, input logic ar,
                        input logic [15:0] eq, input logic er, input logic et,
                        input logic ee, input string tag);
        exp_t e;
        load        = ld;
        load_value  = lv;
        start       = st;
        stop        = sp;
        enable      = en;
        auto_reload = ar;
        e.q = eq; e.run = er; e.tc = et; e.err = ee; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
        enable = 1'b0; auto_reload = 1'b0;
        #3 reset = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load = 1'($urandom); load_value = 16'($urandom); start = 1'($urandom);
            stop = 1'($urandom); enable = 1'($urandom); auto_reload = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst.q", {16'd0, q}, 32'd0);
            check("rst.running", {31'd0, running}, 32'd0);
            check("rst.tc", {31'd0, tc}, 32'd0);
            check("rst.load_err", {31'd0, load_err}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        step(0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, "idle");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, "start_zero");

        // One-shot from 25; enable at the start edge must not decrement.
        step(1, 16'h0025, 0, 0, 0, 0, 16'h0025, 0, 0, 0, "os_load");
        step(0, 16'h0000, 1, 0, 1, 0, 16'h0025, 1, 0, 0, "os_start");
        for (int i = 1; i <= 25; i++) begin
            step(0, 16'h0000, 0, 0, 1, 0, to_bcd(25 - i), (i < 25), (i == 25), 0, "os_tick");
        end
        step(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, "os_after1");
        step(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, "os_after2");

        // Borrow chains.
        step(1, 16'h1000, 0, 0, 0, 0, 16'h1000, 0, 0, 0, "b1_load");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h1000, 1, 0, 0, "b1_start");
        step(0, 16'h0000, 0, 0, 1, 0, 16'h0999, 1, 0, 0, "b1_tick");
        step(1, 16'h0100, 0, 0, 0, 0, 16'h0100, 0, 0, 0, "b2_load");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h0100, 1, 0, 0, "b2_start");
        step(0, 16'h0000, 0, 0, 1, 0, 16'h0099, 1, 0, 0, "b2_tick");

        // Periodic mode: 2,1,0,3,2,1,0,3 with tc on each zero.
        step(1, 16'h0003, 0, 0, 0, 1, 16'h0003, 0, 0, 0, "ar_load");
        step(0, 16'h0000, 1, 0, 0, 1, 16'h0003, 1, 0, 0, "ar_start");
        for (int i = 0; i < 8; i++) begin
            int v;
            v = (i % 4 == 3) ? 3 : 2 - (i % 4);
            step(0, 16'h0000, 0, 0, 1, 1, to_bcd(v), 1, (v == 0), 0, "ar_tick");
        end
        step(0, 16'h0000, 0, 1, 1, 1, 16'h0003, 0, 0, 0, "ar_stop");

        // Invalid load while running, then a valid one.
        step(1, 16'h0042, 0, 0, 0, 0, 16'h0042, 0, 0, 0, "il_load");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h0042, 1, 0, 0, "il_start");
        step(1, 16'h00A5, 0, 0, 0, 0, 16'h0042, 1, 0, 1, "il_bad");
        step(0, 16'h0000, 0, 0, 0, 0, 16'h0042, 1, 0, 0, "il_errclr");
        step(1, 16'h0007, 0, 0, 0, 0, 16'h0007, 0, 0, 0, "il_good");

        // stop / load coincident with the final tick.
        step(1, 16'h0001, 0, 0, 0, 0, 16'h0001, 0, 0, 0, "pr_load");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h0001, 1, 0, 0, "pr_start");
        step(0, 16'h0000, 0, 1, 1, 0, 16'h0001, 0, 0, 0, "pr_stop_en");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h0001, 1, 0, 0, "pr_restart");
        step(1, 16'h0005, 0, 0, 1, 0, 16'h0005, 0, 0, 0, "pr_load_en");
        step(0, 16'h0000, 1, 0, 0, 0, 16'h0005, 1, 0, 0, "pr_start2");

        // Asynchronous reset before the next tick edge.
        load = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b1; auto_reload = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst.q", {16'd0, q}, 32'd0);
        check("arst.running", {31'd0, running}, 32'd0);
        check("arst.tc", {31'd0, tc}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_edge.q", {16'd0, q}, 32'd0);
        check("arst_edge.tc", {31'd0, tc}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, "arst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
